// File: rtl/aes_cipher_feeder_if.sv
// Handshake bundle between the block feeder and the AES cipher core.
interface aes_cipher_feeder_if;
    logic         ciph_in_valid_o;
    logic         ciph_in_ready_i;
    logic         ciph_start_o;
    logic [127:0] ciph_state_init_o;
    logic         ciph_out_valid_i;
    logic         ciph_out_ready_o;
    logic [127:0] ciph_state_i;

    modport master (
        output ciph_in_valid_o, ciph_start_o, ciph_state_init_o, ciph_out_ready_o,
        input  ciph_in_ready_i, ciph_out_valid_i, ciph_state_i
    );

    modport slave (
        input  ciph_in_valid_o, ciph_start_o, ciph_state_init_o, ciph_out_ready_o,
        output ciph_in_ready_i, ciph_out_valid_i, ciph_state_i
    );
endinterface

// File: rtl/aes_cipher_feeder.sv
// Collects four 32-bit words into a 128-bit block, hands it to the cipher core
// and buffers the result for word-wise readout.
module aes_cipher_feeder #(
    parameter bit          AutoStart = 1'b1,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_idx_i,
    input  logic [31:0]         wr_data_i,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic                rd_en_i,
    input  logic [1:0]          rd_idx_i,
    output logic [31:0]         rd_data_o,
    output logic                out_valid_o,
    output logic                busy_o,
    output logic                wr_drop_o,
    output logic [CntWidth-1:0] block_cnt_o,
    aes_cipher_feeder_if.master cif
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [127:0]        r_data_in;
    logic [127:0]        r_data_out;
    logic [3:0]          r_in_written;
    logic [3:0]          r_rd_seen;
    logic                r_out_valid;
    logic                r_wr_drop;
    logic [CntWidth-1:0] r_block_cnt;

    logic       w_clear;
    logic       w_wr_ok;
    logic [3:0] w_written_upd;
    logic       w_submit;
    logic       w_in_valid;
    logic       w_in_hs;
    logic       w_out_ready;
    logic       w_out_hs;
    logic       w_rd_hit;
    logic [3:0] w_seen_upd;

    // Clear wins over a coincident write; writes are refused only while offering.
    assign w_clear       = clear_i & (r_state == ST_IDLE);
    assign w_wr_ok       = wr_en_i & (r_state != ST_REQ) & ~w_clear;
    assign w_written_upd = r_in_written | (w_wr_ok ? (4'(1) << wr_idx_i) : 4'd0);
    assign w_submit      = (r_state == ST_IDLE) & ~w_clear & (w_written_upd == 4'hF)
                         & (AutoStart | start_i);

    // Cipher-side strobes are forced low while reset is held.
    assign w_in_valid  = (r_state == ST_REQ) & ~rst_i;
    assign w_in_hs     = w_in_valid & cif.ciph_in_ready_i;
    assign w_out_ready = (r_state == ST_WAIT) & ~r_out_valid & ~rst_i;
    assign w_out_hs    = w_out_ready & cif.ciph_out_valid_i;

    assign w_rd_hit   = rd_en_i & r_out_valid;
    assign w_seen_upd = r_rd_seen | (w_rd_hit ? (4'(1) << rd_idx_i) : 4'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_submit) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_in_hs)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_out_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_in    <= '0;
            r_data_out   <= '0;
            r_in_written <= '0;
            r_rd_seen    <= '0;
            r_out_valid  <= 1'b0;
            r_wr_drop    <= 1'b0;
            r_block_cnt  <= '0;
        end else if (w_clear) begin
            r_data_in    <= '0;
            r_data_out   <= '0;
            r_in_written <= '0;
            r_rd_seen    <= '0;
            r_out_valid  <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            if (w_wr_ok) r_data_in[{wr_idx_i, 5'd0} +: 32] <= wr_data_i;
            r_in_written <= w_in_hs ? 4'd0 : w_written_upd;
            if (wr_en_i && (r_state == ST_REQ)) r_wr_drop <= 1'b1;
            if (w_out_hs) begin
                r_data_out  <= cif.ciph_state_i;
                r_out_valid <= 1'b1;
                r_rd_seen   <= '0;
                r_block_cnt <= r_block_cnt + CntWidth'(1);
            end else if (w_rd_hit) begin
                r_rd_seen <= w_seen_upd;
                if (w_seen_upd == 4'hF) r_out_valid <= 1'b0;
            end
        end
    end

    assign rd_data_o   = r_data_out[{rd_idx_i, 5'd0} +: 32];
    assign out_valid_o = r_out_valid;
    assign busy_o      = (r_state != ST_IDLE);
    assign wr_drop_o   = r_wr_drop;
    assign block_cnt_o = r_block_cnt;

    assign cif.ciph_in_valid_o   = w_in_valid;
    assign cif.ciph_start_o      = w_in_valid;
    assign cif.ciph_state_init_o = rst_i ? 128'd0 : r_data_in;
    assign cif.ciph_out_ready_o  = w_out_ready;

endmodule

// File: tb/tb_aes_cipher_feeder.sv
// Directed bench for aes_cipher_feeder: one auto-start instance with a 2-bit
// counter and one manual-start instance with the default counter width.
module tb_aes_cipher_feeder;

    logic clk;
    logic rst;

    logic        a_wr_en, a_start, a_clear, a_rd_en;
    logic [1:0]  a_wr_idx, a_rd_idx;
    logic [31:0] a_wr_data, a_rd_data;
    logic        a_out_valid, a_busy, a_wr_drop;
    logic [1:0]  a_cnt;

    logic        m_wr_en, m_start, m_clear, m_rd_en;
    logic [1:0]  m_wr_idx, m_rd_idx;
    logic [31:0] m_wr_data, m_rd_data;
    logic        m_out_valid, m_busy, m_wr_drop;
    logic [15:0] m_cnt;

    aes_cipher_feeder_if a_cif ();
    aes_cipher_feeder_if m_cif ();

    aes_cipher_feeder #(.AutoStart(1'b1), .CntWidth(2)) u_auto (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(a_wr_en), .wr_idx_i(a_wr_idx), .wr_data_i(a_wr_data),
        .start_i(a_start), .clear_i(a_clear),
        .rd_en_i(a_rd_en), .rd_idx_i(a_rd_idx), .rd_data_o(a_rd_data),
        .out_valid_o(a_out_valid), .busy_o(a_busy), .wr_drop_o(a_wr_drop),
        .block_cnt_o(a_cnt), .cif(a_cif)
    );

    aes_cipher_feeder #(.AutoStart(1'b0), .CntWidth(16)) u_man (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(m_wr_en), .wr_idx_i(m_wr_idx), .wr_data_i(m_wr_data),
        .start_i(m_start), .clear_i(m_clear),
        .rd_en_i(m_rd_en), .rd_idx_i(m_rd_idx), .rd_data_o(m_rd_data),
        .out_valid_o(m_out_valid), .busy_o(m_busy), .wr_drop_o(m_wr_drop),
        .block_cnt_o(m_cnt), .cif(m_cif)
    );

    localparam logic [127:0] D0 = 128'hCCDDEEFF_8899AABB_44556677_00112233;
    localparam logic [127:0] D1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] D2 = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
    localparam logic [127:0] D3 = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
    localparam logic [127:0] R0 = 128'h01234567_FEDCBA98_76543210_89ABCDEF;
    localparam logic [127:0] R1 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] R2 = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] R3 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;

    int n_vec = 0;
    int n_err = 0;
    int a_ihs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted input handshakes on the auto instance.
    always @(posedge clk) begin
        if (a_cif.ciph_in_valid_o && a_cif.ciph_in_ready_i) a_ihs <= a_ihs + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic [1:0] idx, input logic [31:0] d);
        a_wr_en = 1'b1; a_wr_idx = idx; a_wr_data = d;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic m_wr(input logic [1:0] idx, input logic [31:0] d);
        m_wr_en = 1'b1; m_wr_idx = idx; m_wr_data = d;
        tick();
        m_wr_en = 1'b0;
    endtask

    task automatic a_blk(input logic [127:0] b);
        for (int k = 0; k < 4; k++) a_wr(2'(k), b[32*k +: 32]);
    endtask

    task automatic a_submit(input int lat);
        repeat (lat) tick();
        a_cif.ciph_in_ready_i = 1'b1;
        tick();
        a_cif.ciph_in_ready_i = 1'b0;
    endtask

    task automatic a_result(input logic [127:0] r);
        a_cif.ciph_out_valid_i = 1'b1;
        a_cif.ciph_state_i     = r;
        tick();
        a_cif.ciph_out_valid_i = 1'b0;
    endtask

    task automatic a_read_all(input string tag, input logic [127:0] exp);
        for (int k = 0; k < 4; k++) begin
            a_rd_en = 1'b1; a_rd_idx = 2'(k);
            #1;
            chk(tag, 128'(a_rd_data), 128'(exp[32*k +: 32]));
            tick();
            a_rd_en = 1'b0;
        end
        chk({tag, "_vld_clr"}, 128'(a_out_valid), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        {a_wr_en, a_start, a_clear, a_rd_en, a_wr_idx, a_rd_idx, a_wr_data} = '0;
        {m_wr_en, m_start, m_clear, m_rd_en, m_wr_idx, m_rd_idx, m_wr_data} = '0;
        a_cif.ciph_in_ready_i = 1'b0; a_cif.ciph_out_valid_i = 1'b0; a_cif.ciph_state_i = '0;
        m_cif.ciph_in_ready_i = 1'b0; m_cif.ciph_out_valid_i = 1'b0; m_cif.ciph_state_i = '0;
        tick(); tick();
        chk("rst_busy",  128'(a_busy), 128'd0);
        chk("rst_inv",   128'(a_cif.ciph_in_valid_o), 128'd0);
        chk("rst_ordy",  128'(a_cif.ciph_out_ready_o), 128'd0);
        chk("rst_ovld",  128'(a_out_valid), 128'd0);
        chk("rst_cnt",   128'(a_cnt), 128'd0);
        chk("rst_drop",  128'(a_wr_drop), 128'd0);
        chk("rst_init",  a_cif.ciph_state_init_o, 128'd0);
        rst = 1'b0;
        tick();

        // Manual start: three words plus start must not submit.
        for (int k = 0; k < 3; k++) m_wr(2'(k), D0[32*k +: 32]);
        m_start = 1'b1; tick(); m_start = 1'b0;
        chk("man_3w_start", 128'(m_busy), 128'd0);
        m_wr(2'd3, D0[127:96]);
        chk("man_4w_nostart", 128'(m_busy), 128'd0);
        m_start = 1'b1; tick(); m_start = 1'b0;
        chk("man_req_busy", 128'(m_busy), 128'd1);
        chk("man_req_inv",  128'(m_cif.ciph_in_valid_o), 128'd1);
        chk("man_req_init", m_cif.ciph_state_init_o, D0);

        // Basic flow.
        a_blk(D0);
        chk("b_req_busy",  128'(a_busy), 128'd1);
        chk("b_req_inv",   128'(a_cif.ciph_in_valid_o), 128'd1);
        chk("b_req_start", 128'(a_cif.ciph_start_o), 128'd1);
        chk("b_req_init",  a_cif.ciph_state_init_o, D0);
        tick(); tick();
        chk("b_hold_inv",  128'(a_cif.ciph_in_valid_o), 128'd1);
        chk("b_hold_init", a_cif.ciph_state_init_o, D0);
        a_cif.ciph_in_ready_i = 1'b1; tick(); a_cif.ciph_in_ready_i = 1'b0;
        chk("b_wait_inv",  128'(a_cif.ciph_in_valid_o), 128'd0);
        chk("b_wait_ordy", 128'(a_cif.ciph_out_ready_o), 128'd1);
        chk("b_ihs",       128'(a_ihs), 128'd1);
        repeat (11) tick();
        a_result(R0);
        chk("b_ovld", 128'(a_out_valid), 128'd1);
        chk("b_cnt",  128'(a_cnt), 128'd1);
        chk("b_idle", 128'(a_busy), 128'd0);
        a_read_all("b_rd", R0);

        // Output stall: second result waits until the first is fully read.
        a_blk(D1); a_submit(0); a_result(R1);
        chk("s_cnt1", 128'(a_cnt), 128'd2);
        a_blk(D2); a_submit(1);
        chk("s_busy", 128'(a_busy), 128'd1);
        a_cif.ciph_out_valid_i = 1'b1; a_cif.ciph_state_i = R2;
        tick(); tick();
        chk("s_ordy0", 128'(a_cif.ciph_out_ready_o), 128'd0);
        a_rd_idx = 2'd0; #1;
        chk("s_hold", 128'(a_rd_data), 128'(R1[31:0]));
        for (int k = 0; k < 3; k++) begin
            a_rd_en = 1'b1; a_rd_idx = 2'(k); tick(); a_rd_en = 1'b0;
            chk("s_ordy_rd", 128'(a_cif.ciph_out_ready_o), 128'd0);
        end
        a_rd_en = 1'b1; a_rd_idx = 2'd3; tick(); a_rd_en = 1'b0;
        a_rd_idx = 2'd0; #1;
        chk("s_vld_fall", 128'(a_out_valid), 128'd0);
        chk("s_ordy1",    128'(a_cif.ciph_out_ready_o), 128'd1);
        chk("s_still_r1", 128'(a_rd_data), 128'(R1[31:0]));
        tick();
        a_cif.ciph_out_valid_i = 1'b0;
        chk("s_cap_vld", 128'(a_out_valid), 128'd1);
        chk("s_cap_cnt", 128'(a_cnt), 128'd3);
        chk("s_cap_w0",  128'(a_rd_data), 128'(R2[31:0]));
        a_read_all("s_rd", R2);

        // Dropped write during REQ, then counter wraps to 0.
        a_blk(D3);
        a_wr(2'd1, 32'hDEADBEEF);
        chk("d_flag", 128'(a_wr_drop), 128'd1);
        chk("d_init", a_cif.ciph_state_init_o, D3);
        a_submit(0); a_result(R3);
        chk("w_cnt0",  128'(a_cnt), 128'd0);
        chk("d_stick", 128'(a_wr_drop), 128'd1);
        a_read_all("d_rd", R3);
        a_blk(D0); a_submit(0); a_result(R0);
        chk("w_cnt1",   128'(a_cnt), 128'd1);
        chk("d_stick2", 128'(a_wr_drop), 128'd1);

        // Clear in IDLE with a coincident write; partial in_written is wiped.
        a_wr(2'd0, 32'h11111111); a_wr(2'd1, 32'h22222222);
        a_clear = 1'b1; a_wr_en = 1'b1; a_wr_idx = 2'd2; a_wr_data = 32'h33333333;
        tick();
        a_clear = 1'b0; a_wr_en = 1'b0; a_rd_idx = 2'd0; #1;
        chk("c_drop",  128'(a_wr_drop), 128'd0);
        chk("c_ovld",  128'(a_out_valid), 128'd0);
        chk("c_init",  a_cif.ciph_state_init_o, 128'd0);
        chk("c_dout",  128'(a_rd_data), 128'd0);
        chk("c_cnt",   128'(a_cnt), 128'd1);
        a_wr(2'd2, 32'h44444444); a_wr(2'd3, 32'h55555555);
        chk("c_nosub", 128'(a_busy), 128'd0);
        a_wr(2'd0, 32'h66666666); a_wr(2'd1, 32'h77777777);
        chk("c_sub",   128'(a_busy), 128'd1);
        chk("c_sinit", a_cif.ciph_state_init_o, 128'h55555555_44444444_77777777_66666666);

        // Reset mid-WAIT abandons the block.
        a_submit(0);
        chk("r_wait_ordy", 128'(a_cif.ciph_out_ready_o), 128'd1);
        rst = 1'b1; #1;
        chk("r_held_ordy", 128'(a_cif.ciph_out_ready_o), 128'd0);
        tick();
        rst = 1'b0;
        chk("r_busy", 128'(a_busy), 128'd0);
        chk("r_inv",  128'(a_cif.ciph_in_valid_o), 128'd0);
        chk("r_strt", 128'(a_cif.ciph_start_o), 128'd0);
        chk("r_init", a_cif.ciph_state_init_o, 128'd0);
        chk("r_cnt",  128'(a_cnt), 128'd0);
        chk("r_drop", 128'(a_wr_drop), 128'd0);
        a_cif.ciph_out_valid_i = 1'b1; a_cif.ciph_state_i = R1; #1;
        chk("r_ordy", 128'(a_cif.ciph_out_ready_o), 128'd0);
        tick(); tick();
        a_cif.ciph_out_valid_i = 1'b0;
        chk("r_noacc_vld", 128'(a_out_valid), 128'd0);
        chk("r_noacc_cnt", 128'(a_cnt), 128'd0);
        chk("r_noacc_dat", 128'(a_rd_data), 128'd0);
        chk("ihs_total",   128'(a_ihs), 128'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_cipher_feeder.md
AES_CIPHER_FEEDER -- requirements
Module: aes_cipher_feeder

Interface
REQ-001 SHALL have parameter AutoStart, default 1; when 1, a block is submitted as soon as all 4 input words are written, and when 0 it waits for start_i.
REQ-002 SHALL have parameter CntWidth, default 16; this is the width of the completed-block counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en_i, input, 1 bit: input-word write strobe.
REQ-006 SHALL have port wr_idx_i, input, 2 bits: input word index; word k maps to data_in bits [32k+31:32k].
REQ-007 SHALL have port wr_data_i, input, 32 bits: input word data.
REQ-008 SHALL have port start_i, input, 1 bit: manual submit pulse, used only when AutoStart=0.
REQ-009 SHALL have port clear_i, input, 1 bit: clear pulse for data_in, data_out and the status flags.
REQ-010 SHALL have port rd_en_i, input, 1 bit: output-word read strobe.
REQ-011 SHALL have port rd_idx_i, input, 2 bits: output word index.
REQ-012 SHALL have port rd_data_o, output, 32 bits: combinational data_out word selected by rd_idx_i.
REQ-013 SHALL have port out_valid_o, output, 1 bit: data_out holds an unread result.
REQ-014 SHALL have port busy_o, output, 1 bit: FSM is not in IDLE.
REQ-015 SHALL have port wr_drop_o, output, 1 bit: sticky flag, a write was dropped.
REQ-016 SHALL have port block_cnt_o, output, CntWidth bits: count of completed blocks.
REQ-017 SHALL have port ciph_in_valid_o, output, 1 bit: block offered to the cipher core.
REQ-018 SHALL have port ciph_in_ready_i, input, 1 bit: cipher core accepts the offered block.
REQ-019 SHALL have port ciph_start_o, output, 1 bit: start qualifier to the cipher core.
REQ-020 SHALL have port ciph_state_init_o, output, 128 bits: equal to data_in.
REQ-021 SHALL have port ciph_out_valid_i, input, 1 bit: cipher result valid.
REQ-022 SHALL have port ciph_out_ready_o, output, 1 bit: feeder can accept the cipher result.
REQ-023 SHALL have port ciph_state_i, input, 128 bits: cipher result.

Function
REQ-024 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-025 SHALL, on wr_en_i in IDLE or WAIT, write word wr_idx_i of data_in and set in_written[wr_idx_i].
REQ-026 SHALL, on wr_en_i in REQ, drop the write, leave data_in unchanged, and set wr_drop_o.
REQ-027 SHALL move IDLE->REQ when in_written==4'hF and either AutoStart=1 or start_i=1.
REQ-028 SHALL ignore start_i when in_written!=4'hF.
REQ-029 SHALL, in REQ, drive ciph_in_valid_o=1 and ciph_start_o=1, and hold ciph_state_init_o stable until the handshake.
REQ-030 SHALL, on ciph_in_valid_o & ciph_in_ready_i, clear in_written and move REQ->WAIT on the next edge; a zero-wait ready gives a 1-cycle REQ.
REQ-031 SHALL drive ciph_out_ready_o=1 only in WAIT with out_valid_o=0.
REQ-032 SHALL, on ciph_out_valid_i & ciph_out_ready_o: capture ciph_state_i into data_out, set out_valid_o, clear rd_seen, increment block_cnt_o (wrapping 2^CntWidth-1 -> 0), and move WAIT->IDLE.
REQ-033 SHALL, on rd_en_i with out_valid_o=1, set rd_seen[rd_idx_i].
REQ-034 SHALL clear out_valid_o on the edge where rd_seen becomes 4'hF.
REQ-035 SHALL make reads with out_valid_o=0 return stale data_out and leave rd_seen unchanged.
REQ-036 SHALL, while out_valid_o=1 in WAIT, stall the cipher result: ciph_out_ready_o=0 and data_out unchanged.
REQ-037 SHALL, when wr_en_i and an IDLE->REQ transition fall in the same cycle, complete the write first; submission uses the updated in_written.
REQ-038 SHALL act on clear_i only in IDLE: zero data_in, in_written, data_out, rd_seen, out_valid_o and wr_drop_o; block_cnt_o is kept.
REQ-039 SHALL ignore clear_i in REQ and WAIT.
REQ-040 SHALL, when clear_i and wr_en_i coincide in IDLE, give clear priority and drop the write without setting wr_drop_o.
REQ-041 SHALL drive busy_o = (state != IDLE).

Reset
REQ-042 SHALL, with rst_i=1 at a clock edge, set state=IDLE and zero data_in, data_out, in_written, rd_seen, block_cnt_o, out_valid_o and wr_drop_o.
REQ-043 SHALL hold all cipher-side outputs at 0 while rst_i=1.
REQ-044 SHALL, on reset in REQ or WAIT, abandon the block without a handshake; a later ciph_out_valid_i is not accepted until a new submission reaches WAIT.

Verification
REQ-045 Bench SHALL cover basic flow (AutoStart=1): write words 0..3 = 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF; ready after 2 cycles; result 128'h0123...CDEF after 12 cycles -> ciph_state_init_o=128'hCCDDEEFF_8899AABB_44556677_00112233, one in-handshake, out_valid_o=1, block_cnt_o=1, rd_data_o words match the result.
REQ-046 Bench SHALL cover output stall: a second block completes in the cipher before the first is read -> ciph_out_ready_o stays 0 and data_out is unchanged until all 4 words are read; capture occurs the cycle after out_valid_o falls.
REQ-047 Bench SHALL cover a dropped write: wr_en_i during REQ -> data_in unchanged, wr_drop_o=1, and the flag stays set until clear_i in IDLE.
REQ-048 Bench SHALL cover manual start (AutoStart=0): start_i with 3 words written -> no REQ; after the 4th word plus start_i -> REQ next cycle.
REQ-049 Bench SHALL cover reset mid-WAIT: rst_i for 1 cycle -> IDLE, all outputs 0, and a following ciph_out_valid_i is not accepted (ciph_out_ready_o=0).
REQ-050 Bench SHALL cover counter wrap (CntWidth=2): 5 blocks -> block_cnt_o sequence 1,2,3,0,1.
